// File: rtl/label_scoreboard.sv
// rtl/label_scoreboard.sv - on-chip accuracy scoreboard with sequential basis-point divider
module label_scoreboard #(
    parameter int N_CLASSES   = 10,
    parameter int LABEL_W     = 4,
    parameter int N_CASES     = 750,
    parameter int CNT_W       = 10,
    parameter int STOP_ON_ERR = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clk_en,
    input  logic               start,
    input  logic               finish,
    input  logic               pred_valid,
    output logic               pred_ready,
    input  logic [LABEL_W-1:0] pred_label,
    input  logic [LABEL_W-1:0] exp_label,
    input  logic [LABEL_W-1:0] class_sel,
    output logic [CNT_W-1:0]   class_miss,
    output logic [CNT_W-1:0]   case_cnt,
    output logic [CNT_W-1:0]   correct_cnt,
    output logic [CNT_W-1:0]   wrong_cnt,
    output logic [CNT_W-1:0]   first_err_idx,
    output logic               mismatch,
    output logic               bad_label,
    output logic [13:0]        acc_bp,
    output logic               done
);

    localparam int IDX_W = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;
    localparam int PW    = CNT_W + 14;
    localparam logic [LABEL_W:0]  NC     = N_CLASSES[LABEL_W:0];
    localparam logic [CNT_W-1:0]  NCASES = N_CASES[CNT_W-1:0];
    localparam logic [CNT_W-1:0]  ALL1   = '1;
    localparam logic [PW-1:0]     BP     = PW'(10000);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DIV, S_DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] miss [N_CLASSES];
    logic [CNT_W-1:0] rem;
    logic [13:0]      quot;
    logic [3:0]       div_i;

    logic             exp_ok, pred_ok, is_match, last_case, stop_now;
    logic [CNT_W-1:0] case_inc;
    logic [PW-1:0]    prod;
    logic [13:0]      prod_lo;
    logic [CNT_W-1:0] rem_cur;
    logic [3:0]       bit_idx;
    logic [CNT_W:0]   trial, trial_sub;
    logic             q_bit;

    // Classify the incoming pair and prepare one restoring-division step
    always_comb begin
        exp_ok    = ({1'b0, exp_label} < NC);
        pred_ok   = ({1'b0, pred_label} < NC);
        is_match  = exp_ok && pred_ok && (pred_label == exp_label);
        case_inc  = case_cnt + CNT_W'(1);
        last_case = (case_inc == NCASES);
        stop_now  = (STOP_ON_ERR != 0) && !is_match;
        prod      = PW'(correct_cnt) * BP;
        prod_lo   = prod[13:0];
        // The first step seeds the remainder with the dividend bits above the quotient field
        rem_cur   = (div_i == 4'd0) ? prod[PW-1:14] : rem;
        bit_idx   = 4'd13 - div_i;
        trial     = {rem_cur, prod_lo[bit_idx]};
        q_bit     = (trial >= {1'b0, case_cnt});
        trial_sub = trial - {1'b0, case_cnt};
    end

    // Per-class miss read; out-of-range selects read zero
    always_comb begin
        class_miss = '0;
        if ({1'b0, class_sel} < NC)
            class_miss = miss[class_sel[IDX_W-1:0]];
    end

    // Run-control FSM, counters and divider
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            pred_ready    <= 1'b0;
            case_cnt      <= '0;
            correct_cnt   <= '0;
            wrong_cnt     <= '0;
            first_err_idx <= ALL1;
            mismatch      <= 1'b0;
            bad_label     <= 1'b0;
            acc_bp        <= '0;
            done          <= 1'b0;
            rem           <= '0;
            quot          <= '0;
            div_i         <= '0;
            for (int i = 0; i < N_CLASSES; i++) miss[i] <= '0;
        end else if (!clk_en) begin
            mismatch <= 1'b0;
        end else begin
            mismatch <= 1'b0;
            if (start) begin
                state         <= S_RUN;
                pred_ready    <= 1'b1;
                case_cnt      <= '0;
                correct_cnt   <= '0;
                wrong_cnt     <= '0;
                first_err_idx <= ALL1;
                bad_label     <= 1'b0;
                acc_bp        <= '0;
                done          <= 1'b0;
                div_i         <= '0;
                for (int i = 0; i < N_CLASSES; i++) miss[i] <= '0;
            end else begin
                case (state)
                    S_RUN: begin
                        if (pred_valid && pred_ready) begin
                            case_cnt <= case_inc;
                            if (is_match) begin
                                correct_cnt <= correct_cnt + CNT_W'(1);
                            end else begin
                                wrong_cnt <= wrong_cnt + CNT_W'(1);
                                mismatch  <= 1'b1;
                                if (first_err_idx == ALL1)
                                    first_err_idx <= case_cnt;
                            end
                            if (!exp_ok || !pred_ok)
                                bad_label <= 1'b1;
                            if (exp_ok && !is_match)
                                miss[exp_label[IDX_W-1:0]] <= miss[exp_label[IDX_W-1:0]] + CNT_W'(1);
                        end
                        if (finish || (pred_valid && pred_ready && (last_case || stop_now))) begin
                            state      <= S_DIV;
                            pred_ready <= 1'b0;
                            div_i      <= '0;
                        end
                    end
                    S_DIV: begin
                        if (case_cnt == '0) begin
                            acc_bp <= '0;
                            done   <= 1'b1;
                            state  <= S_DONE;
                        end else begin
                            rem  <= q_bit ? trial_sub[CNT_W-1:0] : trial[CNT_W-1:0];
                            quot <= {quot[12:0], q_bit};
                            if (div_i == 4'd13) begin
                                acc_bp <= {quot[12:0], q_bit};
                                done   <= 1'b1;
                                state  <= S_DONE;
                            end else begin
                                div_i <= div_i + 4'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_label_scoreboard.sv
// tb/tb_label_scoreboard.sv - scoreboard bench for label_scoreboard
module tb_label_scoreboard;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       clk_en = 1'b1;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic       finish = 1'b0;
    logic       pred_valid = 1'b0;
    logic [3:0] pred_label = '0, exp_label = '0, class_sel = '0;

    logic       pred_ready_a, pred_ready_b;
    logic [9:0] class_miss_a, case_cnt_a, correct_cnt_a, wrong_cnt_a, first_err_idx_a;
    logic [9:0] class_miss_b, case_cnt_b, correct_cnt_b, wrong_cnt_b, first_err_idx_b;
    logic       mismatch_a, bad_label_a, done_a, mismatch_b, bad_label_b, done_b;
    logic [13:0] acc_bp_a, acc_bp_b;

    always #5 clk = ~clk;

    label_scoreboard dut_a (
        .clk(clk), .rst(rst), .clk_en(clk_en), .start(start_a), .finish(finish),
        .pred_valid(pred_valid), .pred_ready(pred_ready_a),
        .pred_label(pred_label), .exp_label(exp_label), .class_sel(class_sel),
        .class_miss(class_miss_a), .case_cnt(case_cnt_a), .correct_cnt(correct_cnt_a),
        .wrong_cnt(wrong_cnt_a), .first_err_idx(first_err_idx_a), .mismatch(mismatch_a),
        .bad_label(bad_label_a), .acc_bp(acc_bp_a), .done(done_a)
    );

    label_scoreboard #(.STOP_ON_ERR(1)) dut_b (
        .clk(clk), .rst(rst), .clk_en(clk_en), .start(start_b), .finish(finish),
        .pred_valid(pred_valid), .pred_ready(pred_ready_b),
        .pred_label(pred_label), .exp_label(exp_label), .class_sel(class_sel),
        .class_miss(class_miss_b), .case_cnt(case_cnt_b), .correct_cnt(correct_cnt_b),
        .wrong_cnt(wrong_cnt_b), .first_err_idx(first_err_idx_b), .mismatch(mismatch_b),
        .bad_label(bad_label_b), .acc_bp(acc_bp_b), .done(done_b)
    );

    typedef struct {
        int cases, correct, wrong, ferr, bad, acc, lat, term;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t e_mon;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mm_cnt_a = 0;
    bit en_toggle = 1'b0;
    bit use_b = 1'b0;
    logic done_a_q = 1'b0, done_b_q = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic cmp_rec(input string tag, input exp_t e, input int cc, input int cr,
                           input int wr, input int fe, input int bd, input int ac);
        chk({tag, "_case_cnt"}, cc, e.cases);
        chk({tag, "_correct_cnt"}, cr, e.correct);
        chk({tag, "_wrong_cnt"}, wr, e.wrong);
        chk({tag, "_first_err_idx"}, fe, e.ferr);
        chk({tag, "_bad_label"}, bd, e.bad);
        chk({tag, "_acc_bp"}, ac, e.acc);
        if (e.lat != 0) chk({tag, "_latency"}, cyc - e.term + 1, e.lat);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // clk_en driver: steady high, or toggling every cycle when requested
    always @(posedge clk) begin
        #1;
        clk_en = en_toggle ? ~clk_en : 1'b1;
    end

    always @(negedge clk) if (mismatch_a) mm_cnt_a++;

    // Monitor: each rising done pops the expected run result for that instance
    always @(negedge clk) begin
        if (done_a && !done_a_q) begin
            if (qa.size() == 0) chk("unexpected_done_a", qa.size(), 1);
            else begin
                e_mon = qa.pop_front();
                cmp_rec("a", e_mon, int'(case_cnt_a), int'(correct_cnt_a), int'(wrong_cnt_a),
                        int'(first_err_idx_a), int'(bad_label_a), int'(acc_bp_a));
            end
        end
        if (done_b && !done_b_q) begin
            if (qb.size() == 0) chk("unexpected_done_b", qb.size(), 1);
            else begin
                e_mon = qb.pop_front();
                cmp_rec("b", e_mon, int'(case_cnt_b), int'(correct_cnt_b), int'(wrong_cnt_b),
                        int'(first_err_idx_b), int'(bad_label_b), int'(acc_bp_b));
            end
        end
        done_a_q = done_a;
        done_b_q = done_b;
    end

    task automatic push(input bit b, input int cases, input int correct, input int wrong,
                        input int ferr, input int bad, input int acc, input int lat);
        exp_t e;
        e.cases = cases; e.correct = correct; e.wrong = wrong; e.ferr = ferr;
        e.bad = bad; e.acc = acc; e.lat = lat; e.term = cyc;
        if (b) qb.push_back(e); else qa.push_back(e);
    endtask

    task automatic send(input logic [3:0] p, input logic [3:0] e, input bit fin);
        bit acc;
        int guard;
        pred_label = p; exp_label = e; pred_valid = 1'b1; finish = fin; guard = 0;
        do begin
            @(negedge clk);
            acc = (use_b ? pred_ready_b : pred_ready_a) && clk_en;
            @(posedge clk);
            guard++;
        end while (!acc && guard < 200);
        #1;
        pred_valid = 1'b0;
        finish = 1'b0;
        if (!acc) chk("send_accept_timeout", guard, 0);
    endtask

    task automatic pulse_start(input bit b);
        if (b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic pulse_finish();
        finish = 1'b1;
        @(posedge clk);
        #1;
        finish = 1'b0;
    endtask

    task automatic wait_done(input bit b, input int limit);
        int n = 0;
        while (!(b ? done_b : done_a) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!(b ? done_b : done_a)) chk("done_timeout", n, -1);
    endtask

    task automatic full_run(input int lat);
        logic [3:0] e, p;
        for (int i = 0; i < 750; i++) begin
            e = 4'(i % 10);
            p = (i % 15 == 14) ? 4'((i % 10 + 1) % 10) : e;
            send(p, e, 1'b0);
        end
        push(1'b0, 750, 700, 50, 14, 0, 9333, lat);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        // Reset values while rst is held low
        repeat (3) @(negedge clk);
        chk("rst_case_cnt", int'(case_cnt_a), 0);
        chk("rst_correct_cnt", int'(correct_cnt_a), 0);
        chk("rst_wrong_cnt", int'(wrong_cnt_a), 0);
        chk("rst_first_err_idx", int'(first_err_idx_a), 1023);
        chk("rst_acc_bp", int'(acc_bp_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_pred_ready", int'(pred_ready_a), 0);
        chk("rst_bad_label", int'(bad_label_a), 0);
        chk("rst_class_miss", int'(class_miss_a), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Full 750-case run, 700 matches
        mm_cnt_a = 0;
        pulse_start(1'b0);
        full_run(15);
        wait_done(1'b0, 100);
        chk("full_mismatch_pulses", mm_cnt_a, 50);
        chk("full_ready_after", int'(pred_ready_a), 0);

        // Per-class: ten misses on class 3, ended by finish
        pulse_start(1'b0);
        for (int i = 0; i < 10; i++) send(4'd5, 4'd3, 1'b0);
        pulse_finish();
        push(1'b0, 10, 0, 10, 0, 0, 0, 15);
        wait_done(1'b0, 100);
        for (int s = 0; s < 16; s++) begin
            class_sel = 4'(s);
            #1;
            chk($sformatf("class_miss_%0d", s), int'(class_miss_a), (s == 3) ? 10 : 0);
        end

        // Bad labels; finish coincident with the last accept
        pulse_start(1'b0);
        send(4'd12, 4'd12, 1'b0);
        send(4'd2, 4'd2, 1'b0);
        send(4'd11, 4'd3, 1'b1);
        push(1'b0, 3, 1, 2, 0, 1, 3333, 15);
        wait_done(1'b0, 100);
        class_sel = 4'd3;  #1; chk("bad_class_miss_3", int'(class_miss_a), 1);
        class_sel = 4'd12; #1; chk("bad_class_miss_12", int'(class_miss_a), 0);
        class_sel = 4'd2;  #1; chk("bad_class_miss_2", int'(class_miss_a), 0);

        // STOP_ON_ERR instance: stops on case 5
        use_b = 1'b1;
        pulse_start(1'b1);
        for (int i = 1; i <= 5; i++) send(4'(i), 4'(i), 1'b0);
        send(4'd6, 4'd7, 1'b0);
        push(1'b1, 6, 5, 1, 5, 0, 8333, 15);
        wait_done(1'b1, 100);
        pred_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("stop_ready", int'(pred_ready_b), 0);
        pred_valid = 1'b0;
        chk("stop_case_cnt_hold", int'(case_cnt_b), 6);
        use_b = 1'b0;

        // Abort mid-RUN
        pulse_start(1'b0);
        send(4'd1, 4'd1, 1'b0);
        send(4'd2, 4'd3, 1'b0);
        send(4'd4, 4'd4, 1'b0);
        pulse_start(1'b0);
        @(negedge clk);
        chk("abort_run_case_cnt", int'(case_cnt_a), 0);
        chk("abort_run_wrong_cnt", int'(wrong_cnt_a), 0);
        chk("abort_run_first_err", int'(first_err_idx_a), 1023);
        chk("abort_run_ready", int'(pred_ready_a), 1);
        // Abort mid-DIV
        send(4'd1, 4'd1, 1'b0);
        send(4'd2, 4'd2, 1'b0);
        pulse_finish();
        repeat (4) @(posedge clk);
        #1;
        pulse_start(1'b0);
        @(negedge clk);
        chk("abort_div_case_cnt", int'(case_cnt_a), 0);
        chk("abort_div_correct_cnt", int'(correct_cnt_a), 0);
        chk("abort_div_ready", int'(pred_ready_a), 1);
        chk("abort_div_done", int'(done_a), 0);
        repeat (20) @(negedge clk);
        chk("abort_no_done", int'(done_a), 0);
        // finish with no accepts
        @(posedge clk);
        #1;
        pulse_finish();
        push(1'b0, 0, 0, 0, 1023, 0, 0, 2);
        wait_done(1'b0, 20);

        // Same full run with clk_en toggling
        pulse_start(1'b0);
        mm_cnt_a = 0;
        en_toggle = 1'b1;
        full_run(0);
        wait_done(1'b0, 200);
        en_toggle = 1'b0;
        chk("toggle_mismatch_pulses", mm_cnt_a, 50);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-run
        pulse_start(1'b0);
        class_sel = 4'd4;
        send(4'd1, 4'd1, 1'b0);
        send(4'd13, 4'd2, 1'b0);
        send(4'd3, 4'd4, 1'b0);
        chk("pre_rst_mismatch", int'(mismatch_a), 1);
        chk("pre_rst_bad_label", int'(bad_label_a), 1);
        chk("pre_rst_class_miss", int'(class_miss_a), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_case_cnt", int'(case_cnt_a), 0);
        chk("arst_wrong_cnt", int'(wrong_cnt_a), 0);
        chk("arst_first_err", int'(first_err_idx_a), 1023);
        chk("arst_mismatch", int'(mismatch_a), 0);
        chk("arst_bad_label", int'(bad_label_a), 0);
        chk("arst_ready", int'(pred_ready_a), 0);
        chk("arst_class_miss", int'(class_miss_a), 0);
        chk("arst_done_b", int'(done_b), 0);
        chk("arst_acc_bp_b", int'(acc_bp_b), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        chk("sb_drain", qa.size() + qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/label_scoreboard.md
# label_scoreboard

Synthesizable on-chip accuracy scoreboard for the MLP inference path. It consumes (predicted, expected) label pairs from the MLP wrapper/label ROM, and counts correct and wrong predictions overall and per class. At the end of a run it computes accuracy in basis points with a sequential divider, so a board run reports ACR without a simulator.

## Interface
- N_CLASSES, 10, number of output classes (2..16)
- LABEL_W, 4, label width; 2**LABEL_W >= N_CLASSES
- N_CASES, 750, test cases per run
- CNT_W, 10, counter width; 2**CNT_W > N_CASES required
- STOP_ON_ERR, 0, 1 = end run at first mismatch
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- clk_en  in  1  global clock enable; when low all state holds
- start  in  1  one-cycle pulse: clear all counters and enter RUN
- finish  in  1  one-cycle pulse: end run early (RUN only)
- pred_valid  in  1  pair present
- pred_ready  out  1  scoreboard accepts a pair
- pred_label  in  LABEL_W  HDL prediction
- exp_label  in  LABEL_W  reference label
- class_sel  in  LABEL_W  per-class read select
- class_miss  out  CNT_W  miss count of class class_sel (combinational read)
- case_cnt  out  CNT_W  pairs accepted this run
- correct_cnt  out  CNT_W  matches
- wrong_cnt  out  CNT_W  mismatches (including bad labels)
- first_err_idx  out  CNT_W  case index of first mismatch; all-ones if none
- mismatch  out  1  one-cycle pulse per mismatching accept
- bad_label  out  1  sticky: a label >= N_CLASSES was seen
- acc_bp  out  14  floor(10000*correct_cnt/case_cnt); 0 if case_cnt==0
- done  out  1  high in DONE; acc_bp valid

## Operation
- States: IDLE, RUN, DIV, DONE. Reset state is IDLE. At reset every output and counter is 0, except first_err_idx = all-ones.
- IDLE/DONE: start -> clear counters, per-class array, bad_label, acc_bp. Set first_err_idx all-ones. Go to RUN.
- RUN: pred_ready = 1. An accept is pred_valid & pred_ready & clk_en.
  - Every accept increments case_cnt.
  - Match (pred_label == exp_label and exp_label < N_CLASSES) increments correct_cnt.
  - Otherwise wrong_cnt increments and mismatch pulses.
  - If exp_label < N_CLASSES, class_miss[exp_label] increments.
  - If either label >= N_CLASSES, bad_label is set and the accept counts as wrong.
  - On the first mismatch, first_err_idx is set to the pre-increment case_cnt.
- Leaving RUN for DIV happens on any of:
  - the accept that makes case_cnt == N_CASES;
  - finish;
  - a mismatching accept with STOP_ON_ERR = 1.
- DIV: restoring division of correct_cnt*10000 (CNT_W+14 bits) by case_cnt, one quotient bit per cycle, 14 iterations. If case_cnt == 0, skip directly to DONE with acc_bp = 0.
- DONE: done = 1; outputs hold until start.
- start in RUN or DIV aborts the run: counters clear and the FSM re-enters RUN. start has priority over an accept and over finish in the same cycle. An abort does not assert done.
- finish coincident with an accept: the accept is counted, then the FSM goes to DIV.
- Counters never exceed N_CASES, so no saturation logic is needed.
- rst low at any time: immediate return to the reset values.

## Timing
- Counters, mismatch, and first_err_idx update on the clock edge that accepts the pair; they are visible the next cycle.
- pred_ready is registered from state. It deasserts the cycle after the terminating accept.
- Latency from the terminating accept to done high is 15 cycles (1 state transition + 14 divide).
- With case_cnt == 0, finish to done is 2 cycles.
- clk_en low freezes the FSM, the divider, and the counters. mismatch is not asserted while clk_en is low.
- class_miss is a combinational read of registered state. class_sel >= N_CLASSES reads 0.

## Test plan
- Full run, N_CASES = 750: 750 pairs with 700 matches -> correct_cnt = 700, wrong_cnt = 50, acc_bp = 9333, done 15 cycles after the last accept.
- Per-class: 10 pairs with exp = 3, pred = 5, via finish -> class_miss[3] = 10, others 0, first_err_idx = 0, acc_bp = 0.
- STOP_ON_ERR = 1: cases 0..4 match, case 5 mismatches -> stop with case_cnt = 6, first_err_idx = 5, acc_bp = 8333. Further pred_valid is not accepted.
- Bad label: exp = 12, pred = 12 -> wrong_cnt +1, bad_label = 1, class_miss unchanged.
- start mid-DIV and mid-RUN: all counters read 0 next cycle, the FSM is in RUN, and done never pulses. finish with no accepts -> acc_bp = 0, done after 2 cycles.
- clk_en toggling at 50% and async rst asserted mid-run:
  - with clk_en toggling, counts match the clk_en = 1 run;
  - on rst, all outputs return to reset values without a clock edge.
